// File: rtl/fp_mul_pkg.sv
// Shared types for the FP32 multiplier arbiter: rounding modes, widths and the
// requester tag carried alongside each in-flight multiply.
package fp_mul_pkg;

    localparam int FP_W     = 32;
    localparam int RMODE_W  = 3;
    localparam int TAG_ID_W = 3;    // wide enough for up to 8 requesters

    typedef enum logic [RMODE_W-1:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4
    } rmode_e;

    typedef struct packed {
        logic                vld;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    // Codes above RMM have no meaning to the multiplier and fall back to RNE.
    function automatic logic [RMODE_W-1:0] legal_rmode(input logic [RMODE_W-1:0] mode);
        return (mode <= RMODE_W'(RMM)) ? mode : RMODE_W'(RNE);
    endfunction

endpackage

// File: rtl/fp_mul_arbiter_if.sv
// Requester-side bundle of the multiplier arbiter: operand requests going in,
// one-hot responses coming back.
interface fp_mul_arbiter_if
    import fp_mul_pkg::*;
#(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ-1:0]         req_ready;
    logic [FP_W*N_REQ-1:0]    req_x;
    logic [FP_W*N_REQ-1:0]    req_y;
    logic [RMODE_W*N_REQ-1:0] req_rmode;
    logic [N_REQ-1:0]         rsp_valid;
    logic [FP_W-1:0]          rsp_z;
    logic                     rsp_ovrf;
    logic                     rsp_udrf;

    modport master (
        output req_valid, req_x, req_y, req_rmode,
        input  req_ready, rsp_valid, rsp_z, rsp_ovrf, rsp_udrf
    );

    modport slave (
        input  req_valid, req_x, req_y, req_rmode,
        output req_ready, rsp_valid, rsp_z, rsp_ovrf, rsp_udrf
    );

endinterface

// File: rtl/fp_mul_arbiter_rr.sv
// Combinational round-robin picker: lowest requesting index at or above ptr,
// wrapping to the lowest requesting index overall.
module rr_arbiter
    import fp_mul_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  idx,
    output logic             found
);

    logic [N_REQ-1:0] req_upper;
    logic [N_REQ-1:0] sel;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_upper
        assign req_upper[gi] = req[gi] && (ID_W'(gi) >= ptr);
    end

    always_comb begin
        sel   = (|req_upper) ? req_upper : req;
        found = |sel;
        idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (sel[i]) begin
                idx = ID_W'(i);
            end
        end
        grant = found ? (N_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Round-robin sharing of one pipelined FP32 multiplier between N_REQ requesters.
// Optional sticky overflow/underflow flags per requester: define FP_MUL_ARB_STICKY_EN.
module fp_mul_arbiter
    import fp_mul_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int MUL_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hold,
    fp_mul_arbiter_if.slave    req_bus,
    output logic [FP_W-1:0]    mul_x,
    output logic [FP_W-1:0]    mul_y,
    output logic [RMODE_W-1:0] mul_r_mode,
    input  logic [FP_W-1:0]    mul_z,
    input  logic               mul_ovrf,
    input  logic               mul_udrf,
`ifdef FP_MUL_ARB_STICKY_EN
    input  logic [N_REQ-1:0]   sticky_clr,
    output logic [N_REQ-1:0]   sticky_ovrf,
    output logic [N_REQ-1:0]   sticky_udrf,
`endif
    output logic               busy
);

    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [FP_W-1:0]    x_slice     [N_REQ];
    logic [FP_W-1:0]    y_slice     [N_REQ];
    logic [RMODE_W-1:0] rmode_slice [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
        assign x_slice[gi]     = req_bus.req_x[FP_W*gi +: FP_W];
        assign y_slice[gi]     = req_bus.req_y[FP_W*gi +: FP_W];
        assign rmode_slice[gi] = legal_rmode(req_bus.req_rmode[RMODE_W*gi +: RMODE_W]);
    end

    // ---------------- arbitration ----------------
    logic [ID_W-1:0]  rr_ptr_reg;
    logic [ID_W-1:0]  rr_ptr_next;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_idx;
    logic             grant_found;
    logic             arb_en;

    // Reset suppresses grants so nothing is accepted that would be dropped.
    assign arb_en = !hold && !rst;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr (
        .req   (req_bus.req_valid & {N_REQ{arb_en}}),
        .ptr   (rr_ptr_reg),
        .grant (grant),
        .idx   (grant_idx),
        .found (grant_found)
    );

    assign req_bus.req_ready = grant;

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (grant_found) begin
            rr_ptr_next = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // ---------------- operand registers ----------------
    logic [FP_W-1:0]    mul_x_reg;
    logic [FP_W-1:0]    mul_y_reg;
    logic [RMODE_W-1:0] mul_r_mode_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg     <= '0;
            mul_x_reg      <= '0;
            mul_y_reg      <= '0;
            mul_r_mode_reg <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
            if (grant_found) begin
                mul_x_reg      <= x_slice[grant_idx];
                mul_y_reg      <= y_slice[grant_idx];
                mul_r_mode_reg <= rmode_slice[grant_idx];
            end
        end
    end

    assign mul_x      = mul_x_reg;
    assign mul_y      = mul_y_reg;
    assign mul_r_mode = mul_r_mode_reg;

    // ---------------- tag pipeline ----------------
    // Stage 0 sits beside the operand registers; stages 1..MUL_LAT follow the
    // multiplier, so the last stage lines up with a valid mul_z.
    tag_t             tag_reg [MUL_LAT+1];
    tag_t             tag_next;
    logic [MUL_LAT:0] tag_vld;

    always_comb begin
        tag_next = '0;
        if (grant_found) begin
            tag_next.vld = 1'b1;
            tag_next.id  = TAG_ID_W'(grant_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s <= MUL_LAT; s++) begin
                tag_reg[s] <= '0;
            end
        end else begin
            tag_reg[0] <= tag_next;
            for (int s = 1; s <= MUL_LAT; s++) begin
                tag_reg[s] <= tag_reg[s-1];
            end
        end
    end

    for (genvar gi = 0; gi <= MUL_LAT; gi++) begin : g_vld
        assign tag_vld[gi] = tag_reg[gi].vld;
    end

    assign busy = |tag_vld;

    // ---------------- response registers ----------------
    tag_t             last_tag;
    logic [N_REQ-1:0] rsp_onehot;
    logic [N_REQ-1:0] rsp_valid_reg;
    logic [FP_W-1:0]  rsp_z_reg;
    logic             rsp_ovrf_reg;
    logic             rsp_udrf_reg;

    assign last_tag   = tag_reg[MUL_LAT];
    assign rsp_onehot = last_tag.vld ? (N_REQ'(1) << last_tag.id) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_reg <= '0;
            rsp_z_reg     <= '0;
            rsp_ovrf_reg  <= 1'b0;
            rsp_udrf_reg  <= 1'b0;
        end else begin
            rsp_valid_reg <= rsp_onehot;
            if (last_tag.vld) begin
                rsp_z_reg    <= mul_z;
                rsp_ovrf_reg <= mul_ovrf;
                rsp_udrf_reg <= mul_udrf;
            end
        end
    end

    assign req_bus.rsp_valid = rsp_valid_reg;
    assign req_bus.rsp_z     = rsp_z_reg;
    assign req_bus.rsp_ovrf  = rsp_ovrf_reg;
    assign req_bus.rsp_udrf  = rsp_udrf_reg;

`ifdef FP_MUL_ARB_STICKY_EN
    // ---------------- sticky exception flags ----------------
    logic [N_REQ-1:0] sticky_ovrf_reg;
    logic [N_REQ-1:0] sticky_udrf_reg;
    logic [N_REQ-1:0] set_ovrf;
    logic [N_REQ-1:0] set_udrf;

    assign set_ovrf = mul_ovrf ? rsp_onehot : '0;
    assign set_udrf = mul_udrf ? rsp_onehot : '0;

    // Set is OR-ed in after the clear so a same-cycle event is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_ovrf_reg <= '0;
            sticky_udrf_reg <= '0;
        end else begin
            sticky_ovrf_reg <= (sticky_ovrf_reg & ~sticky_clr) | set_ovrf;
            sticky_udrf_reg <= (sticky_udrf_reg & ~sticky_clr) | set_udrf;
        end
    end

    assign sticky_ovrf = sticky_ovrf_reg;
    assign sticky_udrf = sticky_udrf_reg;
`endif

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter with a two-stage behavioural FP32 multiplier
// standing in for the shared unit.
module tb_fp_mul_arbiter;
    import fp_mul_pkg::*;

    localparam int N   = 4;
    localparam int LAT = 2;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic hold = 1'b0;

    always #5 clk = ~clk;

    fp_mul_arbiter_if #(.N_REQ(N)) bus ();

    logic [31:0] mul_x, mul_y, mul_z;
    logic [2:0]  mul_r_mode;
    logic        mul_ovrf, mul_udrf, busy;
`ifdef FP_MUL_ARB_STICKY_EN
    logic [N-1:0] sticky_clr, sticky_ovrf, sticky_udrf;
`endif

    fp_mul_arbiter #(.N_REQ(N), .MUL_LAT(LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .hold        (hold),
        .req_bus     (bus),
        .mul_x       (mul_x),
        .mul_y       (mul_y),
        .mul_r_mode  (mul_r_mode),
        .mul_z       (mul_z),
        .mul_ovrf    (mul_ovrf),
        .mul_udrf    (mul_udrf),
`ifdef FP_MUL_ARB_STICKY_EN
        .sticky_clr  (sticky_clr),
        .sticky_ovrf (sticky_ovrf),
        .sticky_udrf (sticky_udrf),
`endif
        .busy        (busy)
    );

    // Truncating FP32 multiply, denormals flushed; returns {ovrf, udrf, z}.
    function automatic logic [33:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          e;
        logic [47:0] p;
        logic [22:0] m;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {2'b00, s, 31'd0};
        p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = p[46:24];
            e++;
        end else begin
            m = p[45:23];
        end
        if (e >= 255) return {2'b10, s, 8'hFF, 23'd0};
        if (e <= 0)   return {2'b01, s, 31'd0};
        return {2'b00, s, e[7:0], m};
    endfunction

    logic [33:0] mstage1, mstage2;
    always @(posedge clk) begin
        mstage1 <= fmul(mul_x, mul_y);
        mstage2 <= mstage1;
    end
    assign {mul_ovrf, mul_udrf, mul_z} = mstage2;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0]  g_hist [4];
    logic [31:0] z_hist [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [31:0] x, input logic [31:0] y,
                           input logic [2:0] rm);
        bus.req_x[32*id +: 32]   = x;
        bus.req_y[32*id +: 32]   = y;
        bus.req_rmode[3*id +: 3] = rm;
    endtask

    task automatic clr_hist();
        for (int i = 0; i < 4; i++) begin
            g_hist[i] = '0;
            z_hist[i] = '0;
        end
    endtask

    // One cycle: check the grant, clock, then check the response due from the
    // grant three edges earlier and the busy flag.
    task automatic tick(input logic [3:0] exp_rdy, input logic [31:0] exp_z);
        #1;
        chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
        for (int i = 3; i > 0; i--) begin
            g_hist[i] = g_hist[i-1];
            z_hist[i] = z_hist[i-1];
        end
        g_hist[0] = exp_rdy;
        z_hist[0] = exp_z;
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(g_hist[3]));
        if (g_hist[3] != 4'b0) begin
            chk("rsp_z", bus.rsp_z, z_hist[3]);
            $display("rsp valid=%b z=%08h ovrf=%b udrf=%b",
                     bus.rsp_valid, bus.rsp_z, bus.rsp_ovrf, bus.rsp_udrf);
        end
        chk("busy", 32'(busy), 32'(|{g_hist[0], g_hist[1], g_hist[2]}));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clr_hist();
    endtask

    typedef struct {
        int          id;
        logic [31:0] x;
        logic [31:0] y;
        logic [2:0]  rm;
        logic [2:0]  exp_rm;
        logic [31:0] exp_z;
        logic        exp_o;
        logic        exp_u;
    } vec_t;

    vec_t vt [6];

    initial begin
        logic [3:0] g;
        vt[0] = '{0, 32'h40B00000, 32'hC0100000, 3'd0, 3'd0, 32'hC1460000, 1'b0, 1'b0};
        vt[1] = '{1, 32'h7F000000, 32'h7F000000, 3'd0, 3'd0, 32'h7F800000, 1'b1, 1'b0};
        vt[2] = '{2, 32'h3F800000, 32'h3F800000, 3'd3, 3'd3, 32'h3F800000, 1'b0, 1'b0};
        vt[3] = '{3, 32'h00800000, 32'h00800000, 3'd1, 3'd1, 32'h00000000, 1'b0, 1'b1};
        vt[4] = '{0, 32'hBFC00000, 32'hBFC00000, 3'd7, 3'd0, 32'h40100000, 1'b0, 1'b0};
        vt[5] = '{2, 32'h40000000, 32'h40400000, 3'd5, 3'd0, 32'h40C00000, 1'b0, 1'b0};

        bus.req_valid = '0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        bus.req_rmode = '0;
`ifdef FP_MUL_ARB_STICKY_EN
        sticky_clr = '0;
`endif
        clr_hist();

        // Reset state: all outputs zero, no grant even with every request up.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.req_valid = 4'hF;
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_mul_x", mul_x, 32'd0);
        chk("rst_mul_y", mul_y, 32'd0);
        chk("rst_mul_r_mode", 32'(mul_r_mode), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_z", bus.rsp_z, 32'd0);
        chk("rst_rsp_flags", 32'({bus.rsp_ovrf, bus.rsp_udrf}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        bus.req_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single-requester vectors.
        for (int v = 0; v < 6; v++) begin
            set_req(vt[v].id, vt[v].x, vt[v].y, vt[v].rm);
            bus.req_valid = 4'(1 << vt[v].id);
            tick(4'(1 << vt[v].id), vt[v].exp_z);
            bus.req_valid = '0;
            chk("mul_x", mul_x, vt[v].x);
            chk("mul_y", mul_y, vt[v].y);
            chk("mul_r_mode", 32'(mul_r_mode), 32'(vt[v].exp_rm));
            repeat (3) tick(4'b0, 32'd0);
            chk("rsp_ovrf", 32'(bus.rsp_ovrf), 32'(vt[v].exp_o));
            chk("rsp_udrf", 32'(bus.rsp_udrf), 32'(vt[v].exp_u));
        end

`ifdef FP_MUL_ARB_STICKY_EN
        chk("sticky_ovrf", 32'(sticky_ovrf), 32'h2);
        chk("sticky_udrf", 32'(sticky_udrf), 32'h8);
        sticky_clr = 4'b0010;
        @(posedge clk);
        #1;
        sticky_clr = '0;
        chk("sticky_ovrf_clr", 32'(sticky_ovrf), 32'h0);
        chk("sticky_udrf_kept", 32'(sticky_udrf), 32'h8);
        set_req(1, 32'h7F000000, 32'h7F000000, 3'd0);
        bus.req_valid = 4'b0010;
        tick(4'b0010, 32'h7F800000);
        bus.req_valid = '0;
        tick(4'b0, 32'd0);
        tick(4'b0, 32'd0);
        sticky_clr = 4'b0010;
        tick(4'b0, 32'd0);
        sticky_clr = '0;
        chk("sticky_set_wins", 32'(sticky_ovrf), 32'h2);
`endif

        // All four requesters at once after reset: served 0,1,2,3.
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 32'h40000000, 32'h40400000, 3'd0);
        bus.req_valid = 4'hF;
        for (int t = 0; t < 7; t++) begin
            g = (t < 4) ? 4'(1 << t) : 4'b0;
            tick(g, 32'h40C00000);
            bus.req_valid = bus.req_valid & ~g;
        end

        // Requesters 0 and 2 streaming: alternate grants, every op answered.
        set_req(0, 32'h3F800000, 32'h3F800000, 3'd0);
        set_req(2, 32'h40000000, 32'h40400000, 3'd0);
        bus.req_valid = 4'b0101;
        for (int t = 0; t < 11; t++) begin
            if (t == 8) bus.req_valid = '0;
            g = (t < 8) ? ((t % 2 == 0) ? 4'b0001 : 4'b0100) : 4'b0;
            tick(g, (t % 2 == 0) ? 32'h3F800000 : 32'h40C00000);
        end

        // Hold with requests pending: no grants, drain, then resume from rr_ptr.
        do_reset();
        for (int i = 0; i < 3; i++) set_req(i, 32'h3F800000, 32'h3F800000, 3'd0);
        bus.req_valid = 4'b0111;
        tick(4'b0001, 32'h3F800000);
        bus.req_valid = 4'b0110;
        hold = 1'b1;
        repeat (4) tick(4'b0, 32'd0);
        hold = 1'b0;
        tick(4'b0010, 32'h3F800000);
        bus.req_valid = 4'b0100;
        tick(4'b0100, 32'h3F800000);
        bus.req_valid = '0;
        repeat (3) tick(4'b0, 32'd0);

        // Reset one edge after an accept: the op is dropped, the next one is not.
        set_req(0, 32'h40B00000, 32'hC0100000, 3'd0);
        bus.req_valid = 4'b0001;
        tick(4'b0001, 32'hC1460000);
        bus.req_valid = '0;
        do_reset();
        chk("rst2_mul_x", mul_x, 32'd0);
        chk("rst2_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst2_rsp_z", bus.rsp_z, 32'd0);
        chk("rst2_busy", 32'(busy), 32'd0);
        repeat (4) tick(4'b0, 32'd0);
        bus.req_valid = 4'b0001;
        tick(4'b0001, 32'hC1460000);
        bus.req_valid = '0;
        repeat (3) tick(4'b0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
